generation_controller: RTL and testbench

GENERATION_CONTROLLER -- requirements
Module: generation_controller

---
 rtl/generation_controller.sv | 137 +++++++++++++
 tb/tb_generation_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/generation_controller.sv
// generation_controller
//   Sequences a 16x16 cellular-automaton grid: seed loading row by row,
//   stepping from an external rule stage, generation/birth/death counting,
//   and halting on a fixed point, extinction or a generation limit.
//
// Build option:
//   GEN_STATS_EN  defined   -> total_births / total_deaths accumulate
//                 undefined -> both totals are constant 0
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   load_valid/load_row       seed row offer (bit j = column j)
//   load_ready                seed row accepted this cycle (IDLE/LOAD/HALT)
//   run, step_tick            free-run level and single-cycle step strobe
//   next_env, birth_in/out    next grid and its birth/death counts
//   death_in
//   cur_env                   registered current grid, row i = [16i+15:16i]
//   gen_count                 generations applied since the last seed load
//   total_births/deaths       saturating 24-bit accumulators
//   state                     IDLE=0, LOAD=1, RUN=2, HALT=3
//   extinct, stable           sticky halt causes
module generation_controller #(
  parameter int unsigned MAX_GEN = 1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_valid,
  input  logic [15:0]  load_row,
  output logic         load_ready,
  input  logic         run,
  input  logic         step_tick,
  input  logic [255:0] next_env,
  input  logic [8:0]   birth_in,
  input  logic [8:0]   death_in,
  output logic [255:0] cur_env,
  output logic [15:0]  gen_count,
  output logic [23:0]  total_births,
  output logic [23:0]  total_deaths,
  output logic [1:0]   state,
  output logic         extinct,
  output logic         stable
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, HALT = 2'd3} state_t;

  state_t     st;
  logic [3:0] row_cnt;
  logic       grid_loaded;

  logic xfer, first_xfer, do_step;
  logic is_stable, is_zero, at_limit;

  assign state      = st;
  assign load_ready = !rst && (st != RUN);
  assign xfer       = load_valid && load_ready;
  // A transfer outside LOAD starts a fresh seed and clears all history.
  assign first_xfer = xfer && (st != LOAD);
  assign do_step    = (st == RUN) && step_tick;

  // Halt checks look at the grid/count before this step is applied.
  assign is_stable = (next_env == cur_env);
  assign is_zero   = (next_env == '0);
  assign at_limit  = ({1'b0, gen_count} + 17'd1) == 17'(MAX_GEN);

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= IDLE;
      cur_env     <= '0;
      gen_count   <= '0;
      extinct     <= 1'b0;
      stable      <= 1'b0;
      grid_loaded <= 1'b0;
      row_cnt     <= '0;
    end else begin
      case (st)
        IDLE, HALT: begin
          if (xfer) begin
            st             <= LOAD;
            gen_count      <= '0;
            extinct        <= 1'b0;
            stable         <= 1'b0;
            grid_loaded    <= 1'b0;
            cur_env[15:0]  <= load_row;
            row_cnt        <= 4'd1;
          end else if (st == IDLE && run && grid_loaded) begin
            st <= RUN;
          end
        end
        LOAD: begin
          if (xfer) begin
            cur_env[16*row_cnt +: 16] <= load_row;
            row_cnt <= row_cnt + 4'd1;   // wraps to 0 after row 15
            if (row_cnt == 4'd15) begin
              grid_loaded <= 1'b1;
              st          <= IDLE;
            end
          end
        end
        RUN: begin
          if (step_tick) begin
            cur_env   <= next_env;
            gen_count <= gen_count + 16'd1;
            if (is_stable) stable  <= 1'b1;
            if (is_zero)   extinct <= 1'b1;
            // Halt wins over pause when both happen on the same step.
            if (is_stable || is_zero || at_limit) st <= HALT;
            else if (!run)                        st <= IDLE;
          end else if (!run) begin
            st <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef GEN_STATS_EN
  logic [24:0] birth_sum, death_sum;
  assign birth_sum = {1'b0, total_births} + 25'(birth_in);
  assign death_sum = {1'b0, total_deaths} + 25'(death_in);

  always_ff @(posedge clk) begin
    if (rst || first_xfer) begin
      total_births <= '0;
      total_deaths <= '0;
    end else if (do_step) begin
      total_births <= birth_sum[24] ? 24'hFFFFFF : birth_sum[23:0];
      total_deaths <= death_sum[24] ? 24'hFFFFFF : death_sum[23:0];
    end
  end
`else
  assign total_births = '0;
  assign total_deaths = '0;
  logic unused_stats;
  assign unused_stats = ^{birth_in, death_in, first_xfer, do_step};
`endif

endmodule

// File: tb/tb_generation_controller.sv
module tb_generation_controller;
  localparam int MAXG = 1000;
  localparam int IDLE = 0, LOAD = 1, RUN = 2, HALT = 3;

  logic         clk = 1'b0, rst = 1'b1, load_valid = 1'b0, run = 1'b0, step_tick = 1'b0;
  logic [15:0]  load_row = '0;
  logic [255:0] next_env = '0;
  logic [8:0]   birth_in = '0, death_in = '0;

  logic         load_ready, extinct, stable;
  logic [255:0] cur_env;
  logic [15:0]  gen_count;
  logic [23:0]  total_births, total_deaths;
  logic [1:0]   state;

  logic         lim_load_ready, lim_extinct, lim_stable;
  logic [255:0] lim_cur_env;
  logic [15:0]  lim_gen_count;
  logic [23:0]  lim_total_births, lim_total_deaths;
  logic [1:0]   lim_state;

  generation_controller #(.MAX_GEN(MAXG)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_row(load_row),
    .load_ready(load_ready), .run(run), .step_tick(step_tick), .next_env(next_env),
    .birth_in(birth_in), .death_in(death_in), .cur_env(cur_env), .gen_count(gen_count),
    .total_births(total_births), .total_deaths(total_deaths), .state(state),
    .extinct(extinct), .stable(stable));

  generation_controller #(.MAX_GEN(3)) dut_lim (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_row(load_row),
    .load_ready(lim_load_ready), .run(run), .step_tick(step_tick), .next_env(next_env),
    .birth_in(birth_in), .death_in(death_in), .cur_env(lim_cur_env), .gen_count(lim_gen_count),
    .total_births(lim_total_births), .total_deaths(lim_total_deaths), .state(lim_state),
    .extinct(lim_extinct), .stable(lim_stable));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // Reference model state
  int           m_st = IDLE, m_rowc = 0, m_gen = 0;
  bit           m_loaded = 0, m_ext = 0, m_stab = 0;
  logic [255:0] m_env = '0;
  longint       m_tb = 0, m_td = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Conway's rule on a non-wrapping 16x16 grid, standing in for the rule stage.
  function automatic void life(input logic [255:0] g, output logic [255:0] n,
                               output int b, output int d);
    n = '0; b = 0; d = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        int k;
        bit alive, nv;
        k = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 16 && c + dc >= 0 && c + dc < 16)
              k += int'(g[16*(r+dr) + c + dc]);
        alive = g[16*r + c];
        nv = (k == 3) || (alive && k == 2);
        n[16*r + c] = nv;
        if (nv && !alive) b++;
        if (!nv && alive) d++;
      end
  endfunction

  function automatic logic [23:0] tot(input longint v);
`ifdef GEN_STATS_EN
    return 24'(v);
`else
    return (v == v) ? 24'd0 : 24'd0;
`endif
  endfunction

  task automatic check_all();
    chk("state",     256'(state),        256'(m_st));
    chk("cur_env",   cur_env,            m_env);
    chk("gen_count", 256'(gen_count),    256'(m_gen));
    chk("extinct",   256'(extinct),      256'(m_ext));
    chk("stable",    256'(stable),       256'(m_stab));
    chk("births",    256'(total_births), 256'(tot(m_tb)));
    chk("deaths",    256'(total_deaths), 256'(tot(m_td)));
  endtask

  // One clock: drive inputs, advance the model by the rules, compare.
  task automatic cyc(input bit lv, input logic [15:0] row, input bit r, input bit st, input bit rs);
    logic [255:0] nx;
    int b, d;
    life(m_env, nx, b, d);
    load_valid = lv; load_row = row; run = r; step_tick = st; rst = rs;
    next_env = nx; birth_in = b[8:0]; death_in = d[8:0];
    #1;
    chk("load_ready", 256'(load_ready), 256'(!rs && m_st != RUN));
    @(posedge clk);
    if (rs) begin
      m_st = IDLE; m_env = '0; m_gen = 0; m_tb = 0; m_td = 0;
      m_ext = 0; m_stab = 0; m_loaded = 0; m_rowc = 0;
    end else if (m_st == LOAD) begin
      if (lv) begin
        m_env[16*m_rowc +: 16] = row;
        m_rowc++;
        if (m_rowc == 16) begin m_rowc = 0; m_loaded = 1; m_st = IDLE; end
      end
    end else if (m_st == RUN) begin
      if (st) begin
        bit halt;
        halt = (nx == m_env) || (nx == '0) || (m_gen + 1 == MAXG);
        if (nx == m_env) m_stab = 1;
        if (nx == '0)    m_ext  = 1;
        m_env = nx; m_gen++;
        m_tb = (m_tb + b > 64'hFFFFFF) ? 64'hFFFFFF : m_tb + b;
        m_td = (m_td + d > 64'hFFFFFF) ? 64'hFFFFFF : m_td + d;
        m_st = halt ? HALT : (r ? RUN : IDLE);
      end else if (!r) m_st = IDLE;
    end else begin // IDLE or HALT
      if (lv) begin
        m_gen = 0; m_tb = 0; m_td = 0; m_ext = 0; m_stab = 0; m_loaded = 0;
        m_env[15:0] = row; m_rowc = 1; m_st = LOAD;
      end else if (m_st == IDLE && r && m_loaded) m_st = RUN;
    end
    #1;
    check_all();
  endtask

  task automatic do_reset();
    cyc(0, 16'h0, 0, 0, 1);
    cyc(0, 16'h0, 0, 0, 1);
  endtask

  task automatic load_grid(input logic [255:0] g);
    for (int i = 0; i < 16; i++) cyc(1, g[16*i +: 16], 0, 0, 0);
  endtask

  logic [255:0] seed, g3;
  longint tb3, td3;

  initial begin
    // Reset state
    do_reset();
    chk("rst_state", 256'(state), 256'(IDLE));
    chk("rst_env",   cur_env, 256'(0));
    chk("rst_gen",   256'(gen_count), 256'(0));

    // Blinker: period 2, back to seed after 4 steps, stays in RUN
    seed = '0; seed[16*7 +: 16] = 16'h0070;
    load_grid(seed);
    cyc(0, 16'h0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 16'h0, 1, 1, 0);
    chk("blink_gen",   256'(gen_count), 256'(4));
    chk("blink_env",   cur_env, seed);
    chk("blink_state", 256'(state), 256'(RUN));
    cyc(0, 16'h0, 0, 0, 0);

    // Block: fixed point after one step
    seed = '0; seed[16*3 +: 16] = 16'h0018; seed[16*4 +: 16] = 16'h0018;
    load_grid(seed);
    cyc(0, 16'h0, 1, 0, 0);
    cyc(0, 16'h0, 1, 1, 0);
    chk("block_stable", 256'(stable), 256'(1));
    chk("block_state",  256'(state), 256'(HALT));
    chk("block_gen",    256'(gen_count), 256'(1));

    // Single cell dies; load straight out of HALT
    seed = '0; seed[0] = 1'b1;
    load_grid(seed);
    cyc(0, 16'h0, 1, 0, 0);
    cyc(0, 16'h0, 1, 1, 0);
    chk("cell_extinct", 256'(extinct), 256'(1));
    chk("cell_state",   256'(state), 256'(HALT));
`ifdef GEN_STATS_EN
    chk("cell_deaths",  256'(total_deaths), 256'(1));
`endif

    // Zero grid stepping to zero sets both flags
    load_grid('0);
    cyc(0, 16'h0, 1, 0, 0);
    cyc(0, 16'h0, 1, 1, 0);
    chk("zero_ext",  256'(extinct), 256'(1));
    chk("zero_stab", 256'(stable), 256'(1));

    // Reset in the middle of a load discards partial rows
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, 16'($urandom), 0, 0, 0);
    cyc(0, 16'h0, 0, 0, 1);
    load_grid('1);
    chk("rml_env",   cur_env, '1);
    chk("rml_gen",   256'(gen_count), 256'(0));
    chk("rml_state", 256'(state), 256'(IDLE));

    // run drops together with step_tick: step applies, then IDLE
    cyc(0, 16'h0, 1, 0, 0);
    cyc(0, 16'h0, 0, 1, 0);
    chk("pause_gen",   256'(gen_count), 256'(1));
    chk("pause_state", 256'(state), 256'(IDLE));

    // Glider against MAX_GEN=3 instance
    do_reset();
    seed = '0; seed[15:0] = 16'h0002; seed[31:16] = 16'h0004; seed[47:32] = 16'h0007;
    load_grid(seed);
    cyc(0, 16'h0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 16'h0, 1, 1, 0);
      if (i == 2) begin g3 = m_env; tb3 = m_tb; td3 = m_td; end
    end
    chk("lim_gen",    256'(lim_gen_count), 256'(3));
    chk("lim_state",  256'(lim_state), 256'(HALT));
    chk("lim_env",    lim_cur_env, g3);
    chk("lim_flags",  256'({lim_extinct, lim_stable}), 256'(0));
    chk("lim_ready",  256'(lim_load_ready), 256'(1));
    chk("lim_births", 256'(lim_total_births), 256'(tot(tb3)));
    chk("lim_deaths", 256'(lim_total_deaths), 256'(tot(td3)));
    chk("main_gen",   256'(gen_count), 256'(5));
    chk("main_state", 256'(state), 256'(RUN));

    // Randomized: stalled seed loads, then mixed run/step/load/reset traffic
    for (int it = 0; it < 25; it++) begin
      logic [255:0] g;
      int i;
      for (int r = 0; r < 16; r++) g[16*r +: 16] = 16'($urandom & $urandom);
      cyc(0, 16'h0, 0, 0, 0);
      i = 0;
      while (i < 16) begin
        bit lv;
        lv = ($urandom % 3) != 0;
        cyc(lv, g[16*i +: 16], 0, 1'($urandom), 0);
        if (lv) i++;
      end
      for (int c = 0; c < 40; c++)
        cyc(($urandom % 12) == 0, 16'($urandom), ($urandom % 8) != 0,
            1'($urandom), ($urandom % 60) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
